// File: rtl/dmem_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : dmem_arb_pkg
// Brief    : Shared types, constants and address check for dmem_arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dmem_arb_pkg;

    localparam int unsigned MEM_BYTES = 8192;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef logic req_id_t;

    // Out of range or not on an 8-byte word boundary.
    function automatic logic addr_err(input logic [63:0] addr,
                                      input logic [63:0] limit = 64'(MEM_BYTES));
        return (addr >= limit) || (addr[2:0] != 3'b000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
//------------------------------------------------------------------------------
// Module   : rr_arb2
// Brief    : Combinational two-way round-robin picker (one-hot or zero grant).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_valid)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            // On a tie the requester not served last time wins.
            2'b11:   o_gnt = i_last_grant ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : dmem_arbiter
// Brief    : Two-requester round-robin arbiter and strobe sequencer for DataMemory.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned MEM_BYTES = dmem_arb_pkg::MEM_BYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic              req_write_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [DATA_W-1:0] req_wdata_0,
    output logic              resp_valid_0,
    output logic [DATA_W-1:0] resp_rdata_0,
    output logic              resp_err_0,
    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic              req_write_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic              resp_valid_1,
    output logic [DATA_W-1:0] resp_rdata_1,
    output logic              resp_err_1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_MemWrite,
    output logic              mem_MemRead,
    input  logic [DATA_W-1:0] mem_readData
);

    import dmem_arb_pkg::*;

    state_t            r_state;
    state_t            w_next;
    logic              r_last;
    logic              r_write;
    logic              r_err;
    req_id_t           r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_err0;
    logic              r_err1;

    logic [1:0]        w_valid;
    logic [1:0]        w_gnt;
    logic              w_accept;
    logic              w_sel;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_resp_rdata;

    assign w_valid = {req_valid_1, req_valid_0};

    rr_arb2 u_arb (
        .i_valid      (w_valid),
        .i_last_grant (r_last),
        .o_gnt        (w_gnt)
    );

    assign w_accept = (r_state == ST_IDLE) && (w_gnt != 2'b00);
    assign w_sel    = w_gnt[1];
    assign w_addr   = w_sel ? req_addr_1 : req_addr_0;

    // Reset gates ready directly so it drops in the same cycle reset rises.
    assign req_ready_0 = w_accept && w_gnt[0] && !reset;
    assign req_ready_1 = w_accept && w_gnt[1] && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = ST_ISSUE;
            ST_ISSUE: w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last  <= 1'b1;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_id    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_last  <= w_sel;
            r_id    <= w_sel;
            r_write <= w_sel ? req_write_1 : req_write_0;
            r_addr  <= w_addr;
            r_wdata <= w_sel ? req_wdata_1 : req_wdata_0;
            r_err   <= addr_err(64'(w_addr), 64'(MEM_BYTES));
        end
    end

    // Stores and rejected commands return zero data.
    assign w_resp_rdata = (r_write || r_err) ? '0 : mem_readData;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata0 <= '0;
            r_err0   <= 1'b0;
            r_rdata1 <= '0;
            r_err1   <= 1'b0;
        end else if (r_state == ST_RESP) begin
            if (r_id == 1'b0) begin
                r_rdata0 <= w_resp_rdata;
                r_err0   <= r_err;
            end else begin
                r_rdata1 <= w_resp_rdata;
                r_err1   <= r_err;
            end
        end
    end

    always_comb begin
        mem_address   = '0;
        mem_writeData = '0;
        mem_MemWrite  = 1'b0;
        mem_MemRead   = 1'b0;
        resp_valid_0  = 1'b0;
        resp_valid_1  = 1'b0;
        if (r_state == ST_ISSUE) begin
            mem_address   = r_addr;
            mem_writeData = r_wdata;
            mem_MemWrite  = !r_err && r_write;
            mem_MemRead   = !r_err && !r_write;
        end
        if (r_state == ST_RESP) begin
            resp_valid_0 = (r_id == 1'b0);
            resp_valid_1 = (r_id == 1'b1);
        end
        // The live value is shown during the pulse, then held by the register.
        resp_rdata_0 = resp_valid_0 ? w_resp_rdata : r_rdata0;
        resp_err_0   = resp_valid_0 ? r_err        : r_err0;
        resp_rdata_1 = resp_valid_1 ? w_resp_rdata : r_rdata1;
        resp_err_1   = resp_valid_1 ? r_err        : r_err1;
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench: directed scenarios plus random traffic vs model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        v0, v1, w0, w1;
    logic [63:0] a0, a1, d0, d1;
    logic        req_ready_0, req_ready_1, resp_valid_0, resp_valid_1;
    logic        resp_err_0, resp_err_1, mem_MemWrite, mem_MemRead;
    logic [63:0] resp_rdata_0, resp_rdata_1, mem_address, mem_writeData;
    logic [63:0] mem_rd = 64'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid_0(v0), .req_ready_0(req_ready_0), .req_write_0(w0),
        .req_addr_0(a0), .req_wdata_0(d0), .resp_valid_0(resp_valid_0),
        .resp_rdata_0(resp_rdata_0), .resp_err_0(resp_err_0),
        .req_valid_1(v1), .req_ready_1(req_ready_1), .req_write_1(w1),
        .req_addr_1(a1), .req_wdata_1(d1), .resp_valid_1(resp_valid_1),
        .resp_rdata_1(resp_rdata_1), .resp_err_1(resp_err_1),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
        .mem_readData(mem_rd)
    );

    // DataMemory: synchronous read, zero output when no read is issued.
    logic [63:0] mem [1024] = '{default: 64'h0};
    always @(posedge clk) begin
        if (mem_MemWrite) mem[mem_address[12:3]] <= mem_writeData;
        mem_rd <= mem_MemRead ? mem[mem_address[12:3]] : 64'h0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: transaction-level view with 3-cycle occupancy.
    int          cyc = 0;
    logic [63:0] ref_mem [1024] = '{default: 64'h0};
    int          last_m = 1, idle_from = 0, strobe_cyc = -1, resp_cyc = -1, p_id = 0;
    bit          p_good, p_write, p_err;
    logic [63:0] p_addr, p_wdata, p_rdata;
    logic [63:0] held_d [2] = '{default: 64'h0};
    bit          held_e [2] = '{default: 1'b0};
    int          glog[$];
    logic [63:0] rlog0[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_ctl", {58'b0, req_ready_0, req_ready_1, resp_valid_0, resp_valid_1,
                            mem_MemWrite, mem_MemRead}, 64'h0);
            chk("rst_rdata0", resp_rdata_0, 64'h0);
            chk("rst_rdata1", resp_rdata_1, 64'h0);
            chk("rst_err", {62'b0, resp_err_0, resp_err_1}, 64'h0);
            chk("rst_mem_addr", mem_address, 64'h0);
            chk("rst_mem_wdata", mem_writeData, 64'h0);
            last_m = 1; idle_from = 0; strobe_cyc = -1; resp_cyc = -1;
            held_d = '{default: 64'h0}; held_e = '{default: 1'b0};
            glog.delete(); rlog0.delete();
        end else begin
            int win;
            bit eg;
            logic [63:0] ad;
            win = -1;
            if (cyc >= idle_from) begin
                if (v0 && v1)  win = (last_m == 1) ? 0 : 1;
                else if (v0)   win = 0;
                else if (v1)   win = 1;
            end
            chk("ready0", {63'b0, req_ready_0}, {63'b0, win == 0});
            chk("ready1", {63'b0, req_ready_1}, {63'b0, win == 1});
            eg = (cyc == strobe_cyc) && p_good;
            chk("memwrite", {63'b0, mem_MemWrite}, {63'b0, eg && p_write});
            chk("memread",  {63'b0, mem_MemRead},  {63'b0, eg && !p_write});
            if (cyc == strobe_cyc) begin
                chk("mem_addr", mem_address, p_addr);
                if (eg && p_write) chk("mem_wdata", mem_writeData, p_wdata);
            end
            for (int k = 0; k < 2; k++) begin
                bit erv;
                erv = (cyc == resp_cyc) && (p_id == k);
                chk(k == 0 ? "resp_valid0" : "resp_valid1",
                    {63'b0, (k == 0) ? resp_valid_0 : resp_valid_1}, {63'b0, erv});
                if (erv) begin
                    held_d[k] = p_rdata;
                    held_e[k] = p_err;
                    if (k == 0) rlog0.push_back(resp_rdata_0);
                end
                chk(k == 0 ? "resp_rdata0" : "resp_rdata1",
                    (k == 0) ? resp_rdata_0 : resp_rdata_1, held_d[k]);
                chk(k == 0 ? "resp_err0" : "resp_err1",
                    {63'b0, (k == 0) ? resp_err_0 : resp_err_1}, {63'b0, held_e[k]});
            end
            if (win >= 0) begin
                ad      = (win == 0) ? a0 : a1;
                p_id    = win;
                p_addr  = ad;
                p_write = (win == 0) ? w0 : w1;
                p_wdata = (win == 0) ? d0 : d1;
                p_err   = (ad >= 64'd8192) || (ad % 8 != 0);
                p_good  = !p_err;
                p_rdata = (p_good && !p_write) ? ref_mem[ad[12:3]] : 64'h0;
                if (p_good && p_write) ref_mem[ad[12:3]] = p_wdata;
                strobe_cyc = cyc + 1; resp_cyc = cyc + 2; idle_from = cyc + 3;
                last_m = win;
                glog.push_back(win);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive(input int k, input bit wr, input logic [63:0] ad, input logic [63:0] dt);
        bit got;
        got = 1'b0;
        if (k == 0) begin v0 = 1; w0 = wr; a0 = ad; d0 = dt; end
        else        begin v1 = 1; w1 = wr; a1 = ad; d1 = dt; end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((k == 0) ? req_ready_0 : req_ready_1) got = 1'b1;
            @(posedge clk); #1;
        end
        chk("accept_within_bound", {63'b0, got}, 64'd1);
        if (k == 0) v0 = 0; else v1 = 0;
    endtask

    function automatic logic [63:0] rand_addr();
        int r, slot;
        r    = $urandom_range(0, 9);
        slot = $urandom_range(0, 15);
        if (r == 0) return 64'h2000 + 64'(slot) * 8;
        if (r == 1) return 64'(slot) * 8 + 64'($urandom_range(1, 7));
        if (r == 2) return {$urandom, $urandom} | 64'h1_0000_0000;
        if (r < 6)  return 64'(slot) * 8;
        return 64'h1F80 + 64'(slot) * 8;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        v0 = 0; v1 = 0; w0 = 0; w1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);

        drive(0, 1, 64'h20, 64'h123456789ABCDEF0);
        drive(0, 0, 64'h20, 64'h0);
        idle(2);
        chk("st_ld_rdata0", resp_rdata_0, 64'h123456789ABCDEF0);
        chk("st_ld_err0", {63'b0, resp_err_0}, 64'd0);

        drive(1, 1, 64'h2000, 64'h5555);
        idle(2);
        chk("oor_err1", {63'b0, resp_err_1}, 64'd1);
        chk("oor_rdata1", resp_rdata_1, 64'h0);
        drive(1, 0, 64'h1FF8, 64'h0);
        idle(2);
        chk("oor_after_rdata1", resp_rdata_1, 64'h0);
        chk("oor_after_err1", {63'b0, resp_err_1}, 64'd0);

        drive(0, 0, 64'h24, 64'h0);
        idle(2);
        chk("misal_err0", {63'b0, resp_err_0}, 64'd1);
        chk("misal_rdata0", resp_rdata_0, 64'h0);

        drive(0, 1, 64'h1FF8, 64'hAABBCCDDEEFF0011);
        drive(0, 0, 64'h1FF8, 64'h0);
        idle(2);
        chk("bound_rdata0", resp_rdata_0, 64'hAABBCCDDEEFF0011);
        chk("bound_err0", {63'b0, resp_err_0}, 64'd0);

        // Contention from reset: both requesters valid before release.
        reset = 1'b1;
        fork
            begin drive(0, 0, 64'h40, 64'h0); drive(0, 0, 64'h40, 64'h0); end
            begin drive(1, 1, 64'h40, 64'hFEDCBA9876543210);
                  drive(1, 1, 64'h40, 64'hFEDCBA9876543210); end
            begin idle(2); reset = 1'b0; end
        join
        idle(3);
        chk("cont_grants", 64'(glog.size()), 64'd4);
        if (glog.size() >= 4)
            for (int i = 0; i < 4; i++) chk("cont_order", 64'(glog[i]), 64'(i % 2));
        chk("cont_loads", 64'(rlog0.size()), 64'd2);
        if (rlog0.size() >= 2) begin
            chk("cont_load_first", rlog0[0], 64'h0);
            chk("cont_load_second", rlog0[1], 64'hFEDCBA9876543210);
        end

        // Reset during ISSUE of a load.
        drive(0, 0, 64'h20, 64'h0);
        reset = 1'b1;
        #1;
        chk("rst_issue_memread", {63'b0, mem_MemRead}, 64'd0);
        chk("rst_issue_addr", mem_address, 64'h0);
        chk("rst_issue_rdata0", resp_rdata_0, 64'h0);
        idle(2);
        reset = 1'b0;
        pulses = 0;
        repeat (4) begin @(negedge clk); if (resp_valid_0) pulses++; end
        chk("rst_no_resp0", 64'(pulses), 64'd0);
        idle(1);
        fork
            drive(0, 0, 64'h20, 64'h0);
            drive(1, 0, 64'h1FF8, 64'h0);
        join
        idle(3);
        chk("rst_tie_count", 64'(glog.size()), 64'd2);
        if (glog.size() >= 1) chk("rst_first_tie", 64'(glog[0]), 64'd0);

        // Random traffic from both requesters.
        fork
            for (int n = 0; n < 60; n++) begin
                idle($urandom_range(0, 3));
                drive(0, 1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom});
            end
            for (int n = 0; n < 60; n++) begin
                idle($urandom_range(0, 3));
                drive(1, 1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom});
            end
        join
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer placed in front of the 64-bit data memory, `DataMemory`: 1024 × 64-bit words with a synchronous one-cycle read and `readData` forced to zero when no read is issued. Two requesters share the single memory port: requester 0 is the load/store unit and requester 1 is the debug/DMA port. Each requester uses a valid/ready command handshake, with round-robin fairness between them. The block also checks every address for range and alignment, sequences the memory strobes, and returns each response as a one-cycle pulse to the requester that issued the command.

## Interface
Parameters:
- `DATA_W`, 64: data width, matching the memory word.
- `ADDR_W`, 64: byte-address width.
- `MEM_BYTES`, 8192: valid address range is [0, `MEM_BYTES`).

Ports (`i` ∈ {0,1}):
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid_i`  in  1  requester `i` presents a command.
- `req_ready_i`  out  1  command accepted in this cycle.
- `req_write_i`  in  1  1 = store, 0 = load.
- `req_addr_i`  in  `ADDR_W`  byte address.
- `req_wdata_i`  in  `DATA_W`  store data.
- `resp_valid_i`  out  1  one-cycle response pulse.
- `resp_rdata_i`  out  `DATA_W`  load data; 0 for stores and errors.
- `resp_err_i`  out  1  address is out of range or misaligned.
- `mem_address`  out  `ADDR_W`  to `DataMemory.address`.
- `mem_writeData`  out  `DATA_W`  to `DataMemory.writeData`.
- `mem_MemWrite`  out  1  memory write strobe.
- `mem_MemRead`  out  1  memory read strobe.
- `mem_readData`  in  `DATA_W`  from `DataMemory.readData`.

## Operation
- The FSM has three states: IDLE, ISSUE and RESP.
- **IDLE.** If any `req_valid_i` is high:
  - Pick a winner. If only one requester is valid, it wins. If both are valid, the requester that was *not* granted last wins.
  - Assert `req_ready_` for the winner only, combinationally, in the same cycle.
  - At the clock edge, register the winner's write flag, address, data and id, plus the `err` flag, and go to ISSUE.
- **Error flag.** `err` = (addr ≥ `MEM_BYTES`) OR (addr[2:0] ≠ 0).
- **ISSUE.** Drive `mem_address`/`mem_writeData` from the registered command.
  - If `err`=0: assert `mem_MemWrite` for a store or `mem_MemRead` for a load, for exactly one cycle.
  - If `err`=1: assert neither strobe. A bad address never reaches the memory.
  - Go to RESP.
- **RESP.** Pulse `resp_valid_` on the granted requester only.
  - `resp_rdata` = `mem_readData` for a good load; 0 otherwise.
  - `resp_err` = `err`.
  - Go to IDLE.
- **Response holding.** `resp_rdata_`/`resp_err_` are registered and hold their values until the next response to the same requester. The other requester's outputs are unchanged.
- **Round-robin state.** The `last_grant` register updates on each acceptance. Its reset value is 1, so requester 0 wins the first tie.
- **Ready rule.** `req_ready_i` is 0 in ISSUE and RESP. A requester must hold `req_valid_` and its payload stable until it sees `req_ready_`.
- **Backpressure.** There is none on responses. A requester must accept `resp_valid_` whenever it occurs.

## Timing
- Command accepted at edge N (IDLE → ISSUE).
- Memory strobe high in cycle N+1.
- `resp_valid` high in cycle N+2; `DataMemory` read data is sampled in that same cycle.
- Back in IDLE in cycle N+3; the next acceptance can occur at the end of cycle N+3.
- Peak throughput: one transaction per 3 cycles.
- Under continuous contention the grants alternate 0, 1, 0, 1, … Neither requester waits more than one transaction.
- A request that arrives while the FSM is busy is accepted in the next IDLE cycle.
- **Reset (asynchronous):**
  - State → IDLE and `last_grant` → 1.
  - All outputs → 0 immediately: ready, `resp_valid`, `resp_rdata`, `resp_err`, `mem_*`.
  - A transaction in flight is dropped with no response. This includes a reset asserted during ISSUE: the strobe is deasserted at once, so the write may or may not land.

## Structure
- Package `dmem_arb_pkg`:
  - state enum {IDLE, ISSUE, RESP};
  - `MEM_BYTES`;
  - requester-id type (1 bit);
  - the `addr_err(addr)` function.
- Sub-module `rr_arb2`: the combinational two-way round-robin picker. Inputs are `valid[1:0]` and `last_grant`; outputs are `gnt[1:0]` (one-hot or zero).
- The top module holds the FSM, the command registers and the response registers.

## Test plan
- **Single store, then load.** Req0 stores `0x123456789ABCDEF0` at `0x20`, then loads `0x20`. Required: `req_ready0` in the accept cycle, `mem_MemWrite` exactly one cycle later, `resp_valid0` at N+2 with `resp_err0`=0. The load returns `resp_rdata0`=`0x123456789ABCDEF0`.
- **Contention.** Both requesters assert valid continuously from reset. Req0 loads `0x40`; req1 stores `0xFEDCBA9876543210` at `0x40`. Required grant order: 0, 1, 0, 1. Req0's first load returns 0. Its second load returns `0xFEDCBA9876543210`.
- **Out of range.** Req1 stores at `0x2000`. Required: `resp_err1`=1 and no `mem_MemWrite` pulse. A subsequent load of `0x1FF8` returns its prior contents, unchanged.
- **Misaligned.** Req0 loads `0x24`. Required: `resp_err0`=1, `resp_rdata0`=0, and `mem_MemRead` never asserted.
- **Boundary.** Store `0xAABBCCDDEEFF0011` at `0x1FF8`, then load it back. Required: returns the stored value with `resp_err`=0.
- **Reset mid-operation.** Assert `reset` during ISSUE of a req0 load. Required: all outputs 0 in the same cycle and no `resp_valid0` afterwards. After release, the first tie is granted to req0.
